wordline_sequencer: RTL
=======================

# wordline_sequencer

Parametrised, registered successor to the 3-to-8 address decoder in the bitcell/NAND-latch memory array. The block accepts an address with a req/ready handshake and latches it. It then drives a timed access sequence: precharge phase, a one-hot word-line pulse of programmable length, and a completion strobe. It sits between the array controller and the row of NAND-latch bitcells, and replaces the bare combinational decode with glitch-free, registered word lines.

## Interface
Parameters:
- ADDR_W, 3, address width; word-line count is 2**ADDR_W (legal 1..8)
- PRE_CYC, 1, precharge cycles before the word line rises (legal ≥1)
- PULSE_CYC, 2, cycles the selected word line stays high (legal ≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; gates acceptance of new requests only
- req  input  1  access request, level-sensitive
- we  input  1  write (1) / read (0), sampled with adr
- adr  input  ADDR_W  row address, sampled on acceptance
- ready  output  1  block can accept a request this cycle
- pre  output  1  bit-line precharge strobe
- wl  output  2**ADDR_W  word lines, registered, one-hot or all-zero
- wr_en  output  1  write strobe, high with wl during write accesses
- done  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, PRE, ACT, DONE; reset state is IDLE.
- ready = 1 in IDLE and DONE, 0 in PRE and ACT. This is a combinational decode of the state.
- Accept = req & en & ready at a rising edge. On accept, the block latches adr and we, loads the counter with PRE_CYC-1, and goes to PRE.
- PRE: pre=1; the counter decrements each cycle; at 0 the block loads PULSE_CYC-1 and goes to ACT.
- ACT: wl[adr_latched]=1, all other bits 0; wr_en = we_latched; the counter decrements; at 0 the block goes to DONE.
- DONE: done=1 for exactly one cycle. On accept the block goes to PRE (back-to-back access); otherwise it goes to IDLE.
- IDLE: without accept, the block stays in IDLE.
- wl bit i is high only when i equals the latched address. Decode is complete because the address space is a power of two, so no out-of-range case exists.
- en low blocks new acceptance only. An in-flight access always completes. en changing mid-access has no effect on that access.
- req, adr and we changes while ready=0 are ignored. The latched values are used for the whole access. Requests are not queued.
- Counter width is clog2(max(PRE_CYC,PULSE_CYC))+1 bits and never wraps.
- pre, wl and wr_en are never high in the same cycle as each other's phase: pre and wl are mutually exclusive.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, wl=0, pre=0, wr_en=0, done=0, and the latched adr/we are cleared to 0. ready reads 1, but no capture occurs while rst_n is low.
- Reset asserted mid-access aborts the access immediately: wl drops without waiting for the clock, and no done pulse is produced.
- Take acceptance at edge 0:
  - pre is high in cycles 1..PRE_CYC.
  - wl is high in cycles PRE_CYC+1..PRE_CYC+PULSE_CYC.
  - done is high in cycle PRE_CYC+PULSE_CYC+1.
- The earliest next acceptance is at the edge ending the DONE cycle. Peak throughput is one access per PRE_CYC+PULSE_CYC+1 cycles.
- All outputs except ready are registered, so there is no decode glitch on wl.

## Test plan
Defaults ADDR_W=3, PRE_CYC=1, PULSE_CYC=2 unless stated.
- Reset: hold rst_n=0 with req=1 and adr=5 → wl=0, pre=0, done=0, wr_en=0, ready=1, and no access starts until after rst_n rises.
- Read access: req=1, we=0, adr=5 at edge 0 → pre=1 in cycle 1; wl=8'b0010_0000 in cycles 2-3 with wr_en=0; done=1 in cycle 4; ready=1 in cycle 4.
- Write back-to-back: write adr=0, then keep req=1 with adr=7 during DONE → wl=8'h01 with wr_en=1, then pre, then wl=8'h80 with wr_en=1. No IDLE cycle appears between the two accesses.
- Ignored and gated requests:
  - Change adr to 2 and toggle req while in ACT → wl stays on the latched row.
  - en=0 with req=1 in IDLE → no acceptance.
  - Drop en mid-access → the access still completes with done.
- Reset mid-access: assert rst_n=0 while wl=8'h10 → wl=0 immediately, with no done pulse afterwards.
- Parameter sweep: ADDR_W=1, 4; PRE_CYC=3; PULSE_CYC=1, 4 → for every address, wl one-hot on the correct bit for exactly PULSE_CYC cycles, and done exactly PRE_CYC+PULSE_CYC+1 cycles after acceptance.

Source files
------------

// File: rtl/wordline_sequencer.sv
// -----------------------------------------------------------------------------
// wordline_sequencer
//
// Registered row driver for the bitcell/NAND-latch array. A request is
// accepted over a req/ready handshake, the row address and direction are
// latched, and a fixed access sequence follows:
//   precharge (PRE_CYC cycles) -> one-hot word-line pulse (PULSE_CYC cycles)
//   -> one-cycle done strobe.
// Every output except ready comes straight from a flop, so the word lines
// cannot glitch while the address decodes.
//
// Parameters
//   ADDR_W    : row address width; 2**ADDR_W word lines (1..8)
//   PRE_CYC   : precharge cycles before the word line rises (>= 1)
//   PULSE_CYC : cycles the selected word line stays high (>= 1)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, aborts any access in flight
//   en     in   global enable, gates acceptance of new requests only
//   req    in   level-sensitive access request
//   we     in   1 = write, 0 = read; sampled together with adr
//   adr    in   row address, sampled on acceptance
//   ready  out  request can be accepted this cycle (IDLE or DONE)
//   pre    out  bit-line precharge strobe
//   wl     out  word lines, one-hot during the pulse, otherwise all zero
//   wr_en  out  write strobe, high alongside wl on write accesses
//   done   out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module wordline_sequencer #(
  parameter int ADDR_W    = 3,
  parameter int PRE_CYC   = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    adr,
  output logic                 ready,
  output logic                 pre,
  output logic [2**ADDR_W-1:0] wl,
  output logic                 wr_en,
  output logic                 done
);

  localparam int WL_N    = 2 ** ADDR_W;
  localparam int MAX_CYC = (PRE_CYC > PULSE_CYC) ? PRE_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_CYC - 1);

  // Reject illegal parameter sets at elaboration rather than building a
  // sequencer whose counter underflows on load.
  if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
    $error("wordline_sequencer: ADDR_W must be in 1..8");
  end
  if (PRE_CYC < 1) begin : g_bad_pre
    $error("wordline_sequencer: PRE_CYC must be >= 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("wordline_sequencer: PULSE_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ACT  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic              pre_q;
  logic [WL_N-1:0]   wl_q;
  logic              wr_en_q;
  logic              done_q;

  logic              accept;

  // ready is the only combinational output: it must be visible in the same
  // cycle the block enters IDLE or DONE so back-to-back accesses need no gap.
  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = req && en && ready;

  // The output flops are loaded with the value of the phase being entered,
  // so each strobe lines up exactly with its state without a decode stage.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the order of statements cannot matter.
  // NOTE: the latched address/direction are reset along with the control
  // state so a stale row can never be driven after an aborted access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      pre_q   <= 1'b0;
      wl_q    <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= S_PRE;
            cnt_q   <= CNT_PRE;
            adr_q   <= adr;
            we_q    <= we;
            pre_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_PRE: begin
          if (cnt_q == '0) begin
            state_q <= S_ACT;
            cnt_q   <= CNT_PULSE;
            pre_q   <= 1'b0;
            wl_q    <= WL_N'(1) << adr_q;
            wr_en_q <= we_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_ACT: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            wl_q    <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          pre_q   <= 1'b0;
          wl_q    <= '0;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pre   = pre_q;
  assign wl    = wl_q;
  assign wr_en = wr_en_q;
  assign done  = done_q;

endmodule
